mem_sram_responder: RTL and testbench



---
 rtl/mem_sram_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_sram_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_responder.sv
// Single-port SRAM responder: DEPTH-word backing store, pipelined reads, sticky address error, saturating counters.
// Optional per-word even parity (par_inject / parity_err) is built when MEM_SRAM_PARITY_EN is defined.
module mem_sram_responder #(
    parameter int                        DATA_BUS_WIDTH = 64,
    parameter int                        ADDR_BUS_WIDTH = 64,
    parameter int                        DEPTH          = 1024,
    parameter int                        READ_LATENCY   = 1,
    parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_sram_CEN,
    input  logic [ADDR_BUS_WIDTH-1:0] mem_sram_A,
    input  logic [DATA_BUS_WIDTH-1:0] mem_sram_D,
    input  logic                      mem_sram_GWEN,
    output logic [DATA_BUS_WIDTH-1:0] mem_sram_Q,
    output logic                      q_valid,
    output logic                      addr_err,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count,
`ifdef MEM_SRAM_PARITY_EN
    input  logic                      par_inject,
    output logic                      parity_err,
`endif
    input  logic                      clr_stats
);
    localparam int                        IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                        NSTG    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam logic [ADDR_BUS_WIDTH-1:0] DEPTH_A = ADDR_BUS_WIDTH'(DEPTH);

    function automatic logic even_parity(input logic [DATA_BUS_WIDTH-1:0] word);
        return ^word;
    endfunction

    function automatic logic [31:0] stat_next(input logic [31:0] count, input logic inc,
                                              input logic clr);
        logic [31:0] nxt;
        if (clr) begin
            nxt = 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            nxt = count + 32'd1;
        end else begin
            nxt = count;
        end
        return nxt;
    endfunction

    logic [DATA_BUS_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_BUS_WIDTH-1:0] idx_s;
    logic [IDX_W-1:0]          widx_s;
    logic                      in_range_s;
    logic                      rd_acc_s;
    logic                      wr_acc_s;
    logic [DATA_BUS_WIDTH-1:0] rd_word_s;
    logic [DATA_BUS_WIDTH-1:0] pipe_data_r [NSTG];
    logic [NSTG-1:0]           pipe_vld_r;
    logic [DATA_BUS_WIDTH-1:0] fin_data_s;
    logic                      fin_vld_s;
`ifdef MEM_SRAM_PARITY_EN
    logic                      par_mem_r [DEPTH];
    logic                      rd_perr_s;
    logic [NSTG-1:0]           pipe_perr_r;
    logic                      fin_perr_s;
`endif

    // Address decode, access qualification and store lookup; accesses during reset are ignored.
    always_comb begin
        idx_s      = mem_sram_A - BASE_ADDR;
        in_range_s = (mem_sram_A >= BASE_ADDR) && (idx_s < DEPTH_A);
        widx_s     = idx_s[IDX_W-1:0];
        rd_acc_s   = rst_n && !mem_sram_CEN && mem_sram_GWEN;
        wr_acc_s   = rst_n && !mem_sram_CEN && !mem_sram_GWEN;
        if (in_range_s) begin
            rd_word_s = mem_r[widx_s];
        end else begin
            rd_word_s = {DATA_BUS_WIDTH{1'b0}};
        end
    end

`ifdef MEM_SRAM_PARITY_EN
    // Recompute parity over the stored word; out-of-range reads never flag a parity error.
    always_comb begin
        if (in_range_s) begin
            rd_perr_s = even_parity(mem_r[widx_s]) != par_mem_r[widx_s];
        end else begin
            rd_perr_s = 1'b0;
        end
    end
`endif

    // Backing store keeps its contents across rst_n so it can stand in for a hard macro.
    always_ff @(posedge clk) begin
        if (wr_acc_s && in_range_s) begin
            mem_r[widx_s] <= mem_sram_D;
`ifdef MEM_SRAM_PARITY_EN
            par_mem_r[widx_s] <= even_parity(mem_sram_D) ^ par_inject;
`endif
        end
    end

    // Intermediate read stages; only used when the read latency exceeds one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_r <= {NSTG{1'b0}};
            for (int i = 0; i < NSTG; i++) begin
                pipe_data_r[i] <= {DATA_BUS_WIDTH{1'b0}};
            end
`ifdef MEM_SRAM_PARITY_EN
            pipe_perr_r <= {NSTG{1'b0}};
`endif
        end else begin
            pipe_vld_r[0]  <= rd_acc_s;
            pipe_data_r[0] <= rd_word_s;
`ifdef MEM_SRAM_PARITY_EN
            pipe_perr_r[0] <= rd_perr_s;
`endif
            for (int i = 1; i < NSTG; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
`ifdef MEM_SRAM_PARITY_EN
                pipe_perr_r[i] <= pipe_perr_r[i-1];
`endif
            end
        end
    end

    // Select what feeds the output register: the lookup itself at latency 1, else the last stage.
    always_comb begin
        if (READ_LATENCY == 1) begin
            fin_vld_s  = rd_acc_s;
            fin_data_s = rd_word_s;
`ifdef MEM_SRAM_PARITY_EN
            fin_perr_s = rd_perr_s;
`endif
        end else begin
            fin_vld_s  = pipe_vld_r[NSTG-1];
            fin_data_s = pipe_data_r[NSTG-1];
`ifdef MEM_SRAM_PARITY_EN
            fin_perr_s = pipe_perr_r[NSTG-1];
`endif
        end
    end

    // Output register holds Q between reads; status clear takes priority over a new error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_sram_Q <= {DATA_BUS_WIDTH{1'b0}};
            q_valid    <= 1'b0;
            addr_err   <= 1'b0;
            rd_count   <= 32'd0;
            wr_count   <= 32'd0;
`ifdef MEM_SRAM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            q_valid <= fin_vld_s;
            if (fin_vld_s) begin
                mem_sram_Q <= fin_data_s;
            end else begin
                mem_sram_Q <= mem_sram_Q;
            end
            if (clr_stats) begin
                addr_err <= 1'b0;
            end else if ((rd_acc_s || wr_acc_s) && !in_range_s) begin
                addr_err <= 1'b1;
            end else begin
                addr_err <= addr_err;
            end
            rd_count <= stat_next(rd_count, rd_acc_s, clr_stats);
            wr_count <= stat_next(wr_count, wr_acc_s, clr_stats);
`ifdef MEM_SRAM_PARITY_EN
            parity_err <= fin_vld_s && fin_perr_s;
`endif
        end
    end
endmodule

// File: tb/tb_mem_sram_responder.sv
// Scoreboard bench: three responders (latency 1/3/2, base 0/0/16) share one randomized stimulus stream.
// Build with MEM_SRAM_PARITY_EN defined to also exercise the parity feature.
module tb_mem_sram_responder;
    localparam int NL = 3;
    localparam int DEPTH = 1024;

    typedef struct {
        int          lane;
        int          due;
        logic [63:0] data;
        bit          known;
        bit          perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic        gwen = 1'b1;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        clr = 1'b0;
    logic        inj = 1'b0;

    logic [63:0] q_a  [NL];
    logic        qv_a [NL];
    logic        err_a[NL];
    logic [31:0] rc_a [NL];
    logic [31:0] wc_a [NL];
`ifdef MEM_SRAM_PARITY_EN
    logic        pe_a [NL];
`endif

    exp_t        sb[$];
    logic [63:0] mdl   [NL][DEPTH];
    bit          known [NL][DEPTH];
    bit          mperr [NL][DEPTH];
    int unsigned rcnt[NL], wcnt[NL];
    bit          merr[NL];
    logic [63:0] lastq[NL];
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int l);
        case (l)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [63:0] base(input int l);
        return (l == 2) ? 64'd16 : 64'd0;
    endfunction

    mem_sram_responder #(.READ_LATENCY(1), .BASE_ADDR(64'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_sram_CEN(cen), .mem_sram_A(addr), .mem_sram_D(wdata),
        .mem_sram_GWEN(gwen), .mem_sram_Q(q_a[0]), .q_valid(qv_a[0]), .addr_err(err_a[0]),
        .rd_count(rc_a[0]), .wr_count(wc_a[0]),
`ifdef MEM_SRAM_PARITY_EN
        .par_inject(inj), .parity_err(pe_a[0]),
`endif
        .clr_stats(clr));
    mem_sram_responder #(.READ_LATENCY(3), .BASE_ADDR(64'd0)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_sram_CEN(cen), .mem_sram_A(addr), .mem_sram_D(wdata),
        .mem_sram_GWEN(gwen), .mem_sram_Q(q_a[1]), .q_valid(qv_a[1]), .addr_err(err_a[1]),
        .rd_count(rc_a[1]), .wr_count(wc_a[1]),
`ifdef MEM_SRAM_PARITY_EN
        .par_inject(inj), .parity_err(pe_a[1]),
`endif
        .clr_stats(clr));
    mem_sram_responder #(.READ_LATENCY(2), .BASE_ADDR(64'd16)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_sram_CEN(cen), .mem_sram_A(addr), .mem_sram_D(wdata),
        .mem_sram_GWEN(gwen), .mem_sram_Q(q_a[2]), .q_valid(qv_a[2]), .addr_err(err_a[2]),
        .rd_count(rc_a[2]), .wr_count(wc_a[2]),
`ifdef MEM_SRAM_PARITY_EN
        .par_inject(inj), .parity_err(pe_a[2]),
`endif
        .clr_stats(clr));

    task automatic chk(input string name, input int l, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lane%0d cyc%0d: got %h expected %h", name, l, cyc, act, exp);
        end
    endtask

    // One clock of stimulus, then advance the reference model by the rules for that edge.
    task automatic access(input bit c, input bit g, input logic [63:0] a, input logic [63:0] d,
                          input bit cl, input bit pi);
        cen = c; gwen = g; addr = a; wdata = d; clr = cl; inj = pi;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            sb.delete();
            for (int l = 0; l < NL; l++) begin
                rcnt[l] = 0; wcnt[l] = 0; merr[l] = 1'b0; lastq[l] = 64'd0;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                bit inr;
                int ix;
                exp_t e;
                inr = (a >= base(l)) && ((a - base(l)) < 64'd1024);
                ix  = inr ? int'(a - base(l)) : 0;
                if (!c && g) begin
                    e.lane = l; e.due = cyc + lat(l) - 1;
                    e.data = inr ? mdl[l][ix] : 64'd0;
                    e.known = inr ? known[l][ix] : 1'b1;
                    e.perr = inr ? mperr[l][ix] : 1'b0;
                    sb.push_back(e);
                    if (rcnt[l] != 32'hFFFF_FFFF) rcnt[l]++;
                end
                if (!c && !g) begin
                    if (inr) begin
                        mdl[l][ix] = d; known[l][ix] = 1'b1; mperr[l][ix] = pi;
                    end
                    if (wcnt[l] != 32'hFFFF_FFFF) wcnt[l]++;
                end
                if (!c && !inr) merr[l] = 1'b1;
                if (cl) begin
                    rcnt[l] = 0; wcnt[l] = 0; merr[l] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) access(1'b1, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    // Monitor: pops the oldest expectation of a lane whenever that lane presents q_valid.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int l = 0; l < NL; l++) begin
                int k;
                exp_t e;
                k = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (k < 0 && sb[j].lane == l) k = j;
                end
                if (qv_a[l]) begin
                    if (k < 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_qvalid lane%0d cyc%0d: got 1 expected 0", l, cyc);
                    end else begin
                        e = sb[k];
                        sb.delete(k);
                        chk("latency_due_cycle", l, 64'(cyc), 64'(e.due));
                        if (e.known) chk("read_data", l, q_a[l], e.data);
`ifdef MEM_SRAM_PARITY_EN
                        if (e.known) chk("parity_err", l, 64'(pe_a[l]), 64'(e.perr));
`endif
                        lastq[l] = e.known ? e.data : q_a[l];
                    end
                end else begin
                    if (k >= 0 && sb[k].due <= cyc) begin
                        tests++; fails++;
                        $display("FAIL missing_qvalid lane%0d cyc%0d: got 0 expected 1 (due %0d)", l, cyc, sb[k].due);
                        sb.delete(k);
                    end
                    chk("q_hold", l, q_a[l], lastq[l]);
`ifdef MEM_SRAM_PARITY_EN
                    chk("parity_err_idle", l, 64'(pe_a[l]), 64'd0);
`endif
                end
                chk("addr_err", l, 64'(err_a[l]), 64'(merr[l]));
                chk("rd_count", l, 64'(rc_a[l]), 64'(rcnt[l]));
                chk("wr_count", l, 64'(wc_a[l]), 64'(wcnt[l]));
            end
        end
    end

    initial begin
        logic [63:0] a;
        int r;
        rst_n = 1'b0;
        idle(1);
        mon_en = 1'b1;
        idle(1);
        rst_n = 1'b1;
        idle(1);

        access(1'b0, 1'b0, 64'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'd5, 64'd0, 1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 64'(i), 64'(10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) access(1'b0, 1'b1, 64'(i), 64'd0, 1'b0, 1'b0);
        idle(4);

        access(1'b0, 1'b1, 64'd1024, 64'd0, 1'b0, 1'b0);
        access(1'b0, 1'b0, 64'd2000, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'd5, 64'd0, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'd15, 64'd0, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'd1039, 64'd0, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0);
        idle(4);
        access(1'b1, 1'b1, 64'd0, 64'd0, 1'b1, 1'b0);
        access(1'b0, 1'b1, 64'd3000, 64'd0, 1'b1, 1'b0);
        idle(4);

        access(1'b0, 1'b0, 64'd7, 64'h0707_0707_0707_0707, 1'b0, 1'b0);
        access(1'b0, 1'b0, 64'd23, 64'h2323_2323_2323_2323, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'd7, 64'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        access(1'b0, 1'b0, 64'd7, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b1;
        idle(3);
        access(1'b0, 1'b1, 64'd7, 64'd0, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'd23, 64'd0, 1'b0, 1'b0);
        idle(4);

        access(1'b0, 1'b0, 64'd9, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        access(1'b0, 1'b1, 64'd9, 64'd0, 1'b0, 1'b0);
        access(1'b0, 1'b0, 64'd9, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        access(1'b0, 1'b1, 64'd9, 64'd0, 1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            case (r % 8)
                0:       a = 64'd1016 + 64'($urandom_range(0, 30));
                1:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, 40));
            endcase
            if (r == 99) begin
                rst_n = 1'b0;
                idle(int'($urandom_range(1, 3)));
                rst_n = 1'b1;
            end else begin
                access(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, a,
                       {$urandom, $urandom}, (r == 50), $urandom_range(0, 3) == 0);
            end
        end
        idle(6);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_empty: got %0d pending reads expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
